// File: rtl/axi_dec_pkg.sv
// Shared defaults for the ordered address decoder: widths, region map,
// default routing ID and the outstanding-count state encoding.
package axi_dec_pkg;

    localparam int ADDR_W_DEF      = 32;
    localparam int SID_W_DEF       = 4;
    localparam int MAX_OUT_DEF     = 4;
    localparam int NUM_REGIONS_DEF = 6;
    localparam int DEFAULT_SID_DEF = NUM_REGIONS_DEF;

    // Region 0 sits in the least significant slot, region 5 in the most.
    localparam logic [NUM_REGIONS_DEF-1:0][ADDR_W_DEF-1:0] REGION_BASE_DEF = {
        32'h2000_0000,
        32'h1001_0000,
        32'h1002_0000,
        32'h0002_0000,
        32'h0001_0000,
        32'h0000_0000
    };

    localparam logic [NUM_REGIONS_DEF-1:0][ADDR_W_DEF-1:0] REGION_LIMIT_DEF = {
        32'h201F_FFFF,
        32'h1001_03FF,
        32'h1002_0400,
        32'h0002_FFFF,
        32'h0001_FFFF,
        32'h0000_1FFF
    };

    // Occupancy of the accepted-but-unretired transaction counter.
    typedef enum logic [1:0] {
        CNT_IDLE   = 2'd0,
        CNT_ACTIVE = 2'd1,
        CNT_FULL   = 2'd2
    } cnt_state_t;

endpackage

// File: rtl/addr_region_match.sv
// Combinational priority matcher: maps an address onto the lowest-indexed
// region whose inclusive [base, limit] window contains it.
module addr_region_match
    import axi_dec_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int NUM_REGIONS = NUM_REGIONS_DEF,
    parameter int SID_W       = SID_W_DEF,
    parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0] REGION_BASE  = REGION_BASE_DEF,
    parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0] REGION_LIMIT = REGION_LIMIT_DEF,
    parameter int DEFAULT_SID = NUM_REGIONS
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [SID_W-1:0]  sid,
    output logic              decerr
);

    // Scan from the highest index down so the lowest matching index is the last writer.
    always_comb begin
        sid    = SID_W'(DEFAULT_SID);
        decerr = 1'b1;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if ((addr >= REGION_BASE[i]) && (addr <= REGION_LIMIT[i])) begin
                sid    = SID_W'(i);
                decerr = 1'b0;
            end
        end
    end

endmodule

// File: rtl/axi_ordered_decoder.sv
// Address decoder with a single registered output stage that keeps responses
// ordered: while transactions are in flight, requests to a different slave
// are held off, and at most MAX_OUT transactions may be outstanding.
module axi_ordered_decoder
    import axi_dec_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int NUM_REGIONS = NUM_REGIONS_DEF,
    parameter int SID_W       = SID_W_DEF,
    parameter int MAX_OUT     = MAX_OUT_DEF,
    parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0] REGION_BASE  = REGION_BASE_DEF,
    parameter logic [NUM_REGIONS-1:0][ADDR_W-1:0] REGION_LIMIT = REGION_LIMIT_DEF,
    parameter int DEFAULT_SID = NUM_REGIONS,
    localparam int CNT_W      = $clog2(MAX_OUT + 1)
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [ADDR_W-1:0] s_addr,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [ADDR_W-1:0] m_addr,
    output logic [SID_W-1:0]  m_sid,
    output logic              m_decerr,
    input  logic              rsp_done,
    output logic [CNT_W-1:0]  out_cnt
);

    logic [SID_W-1:0]  dec_sid;
    logic              dec_err;

    logic              vld_p1;
    logic [ADDR_W-1:0] addr_p1;
    logic [SID_W-1:0]  sid_p1;
    logic              decerr_p1;

    logic [SID_W-1:0]  last_sid;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    cnt_state_t        state;
    cnt_state_t        state_nxt;

    logic              stall;
    logic              s_hs;
    logic              retire;

    addr_region_match #(
        .ADDR_W       (ADDR_W),
        .NUM_REGIONS  (NUM_REGIONS),
        .SID_W        (SID_W),
        .REGION_BASE  (REGION_BASE),
        .REGION_LIMIT (REGION_LIMIT),
        .DEFAULT_SID  (DEFAULT_SID)
    ) u_match (
        .addr   (s_addr),
        .sid    (dec_sid),
        .decerr (dec_err)
    );

    // Full stalls unless a retirement frees a slot this cycle; a slave switch
    // stalls until everything in flight has retired.
    assign stall   = ((state == CNT_FULL) && !rsp_done) ||
                     ((state != CNT_IDLE) && (dec_sid != last_sid));
    assign s_ready = ARESETn && (!vld_p1 || m_ready) && !stall;
    assign s_hs    = s_valid && s_ready;
    // A retirement with nothing outstanding is spurious and is dropped.
    assign retire  = rsp_done && (cnt != '0);

    assign m_valid  = vld_p1;
    assign m_addr   = addr_p1;
    assign m_sid    = sid_p1;
    assign m_decerr = decerr_p1;
    assign out_cnt  = cnt;

    // Output register: load on accept, drop valid once downstream takes it, else hold.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            vld_p1    <= 1'b0;
            addr_p1   <= '0;
            sid_p1    <= '0;
            decerr_p1 <= 1'b0;
        end else if (s_hs) begin
            vld_p1    <= 1'b1;
            addr_p1   <= s_addr;
            sid_p1    <= dec_sid;
            decerr_p1 <= dec_err;
        end else if (m_ready) begin
            vld_p1    <= 1'b0;
        end
    end

    // Remember the slave of the most recently accepted request.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            last_sid <= '0;
        end else if (s_hs) begin
            last_sid <= dec_sid;
        end
    end

    // Outstanding count and its occupancy state.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            cnt   <= '0;
            state <= CNT_IDLE;
        end else begin
            cnt   <= cnt_nxt;
            state <= state_nxt;
        end
    end

    // Next count from accept/retire, and the occupancy state it implies.
    always_comb begin
        cnt_nxt   = cnt;
        state_nxt = state;
        case ({s_hs, retire})
            2'b10:   cnt_nxt = cnt + CNT_W'(1);
            2'b01:   cnt_nxt = cnt - CNT_W'(1);
            default: cnt_nxt = cnt;
        endcase
        if (cnt_nxt == '0) begin
            state_nxt = CNT_IDLE;
        end else if (cnt_nxt == CNT_W'(MAX_OUT)) begin
            state_nxt = CNT_FULL;
        end else begin
            state_nxt = CNT_ACTIVE;
        end
    end

endmodule

// File: tb/tb_axi_ordered_decoder.sv
// Directed bench for the ordered decoder with hand-computed expectations.
module tb_axi_ordered_decoder;

    logic        ACLK;
    logic        ARESETn;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_addr;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_addr;
    logic [3:0]  m_sid;
    logic        m_decerr;
    logic        rsp_done;
    logic [2:0]  out_cnt;

    int n_tests;
    int n_fail;

    axi_ordered_decoder dut (
        .ACLK     (ACLK),
        .ARESETn  (ARESETn),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_addr   (s_addr),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_addr   (m_addr),
        .m_sid    (m_sid),
        .m_decerr (m_decerr),
        .rsp_done (rsp_done),
        .out_cnt  (out_cnt)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    // Accept one request, check the registered result, then retire it.
    task automatic issue(input logic [31:0] a, input logic [3:0] sid, input logic err);
        s_valid = 1'b1;
        s_addr  = a;
        #1;
        check("issue_s_ready", s_ready, 1'b1);
        tick();
        s_valid = 1'b0;
        check("issue_m_valid", m_valid, 1'b1);
        check("issue_m_addr", m_addr, a);
        check("issue_m_sid", m_sid, sid);
        check("issue_m_decerr", m_decerr, err);
        check("issue_out_cnt", out_cnt, 3'd1);
        rsp_done = 1'b1;
        tick();
        rsp_done = 1'b0;
        check("retire_out_cnt", out_cnt, 3'd0);
        check("retire_m_valid", m_valid, 1'b0);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        ARESETn  = 1'b0;
        s_valid  = 1'b0;
        s_addr   = 32'h0;
        m_ready  = 1'b1;
        rsp_done = 1'b0;

        // Reset state
        #1;
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_out_cnt", out_cnt, 3'd0);
        check("rst_m_addr", m_addr, 32'h0);
        check("rst_m_sid", m_sid, 4'd0);
        repeat (2) @(posedge ACLK);
        @(negedge ACLK);
        ARESETn = 1'b1;

        // Mapped regions, first one taken on the first edge after release
        issue(32'h0000_1FFC, 4'd0, 1'b0);
        issue(32'h0001_0004, 4'd1, 1'b0);
        issue(32'h1001_03FF, 4'd4, 1'b0);
        issue(32'h201F_FFFF, 4'd5, 1'b0);

        // Unmapped addresses, including just past region 3's limit
        issue(32'h1002_0404, 4'd6, 1'b1);
        issue(32'h3000_0000, 4'd6, 1'b1);
        issue(32'h1002_0400, 4'd3, 1'b0);

        // Back-to-back throughput to one slave
        s_valid = 1'b1;
        s_addr  = 32'h0002_0000;
        tick();
        s_addr  = 32'h0002_0004;
        #1;
        check("b2b_s_ready", s_ready, 1'b1);
        check("b2b_first_addr", m_addr, 32'h0002_0000);
        tick();
        s_valid = 1'b0;
        check("b2b_second_addr", m_addr, 32'h0002_0004);
        check("b2b_out_cnt", out_cnt, 3'd2);
        rsp_done = 1'b1;
        tick();
        tick();
        rsp_done = 1'b0;
        check("b2b_drain_cnt", out_cnt, 3'd0);

        // Slave switch blocked while in flight
        s_valid = 1'b1;
        s_addr  = 32'h0001_0000;
        tick();
        s_addr  = 32'h0002_0000;
        #1;
        check("sw_s_ready_blocked", s_ready, 1'b0);
        tick();
        check("sw_cnt_held", out_cnt, 3'd1);
        check("sw_m_valid_drained", m_valid, 1'b0);
        rsp_done = 1'b1;
        #1;
        check("sw_still_blocked", s_ready, 1'b0);
        tick();
        rsp_done = 1'b0;
        #1;
        check("sw_cnt_zero", out_cnt, 3'd0);
        check("sw_s_ready_open", s_ready, 1'b1);
        tick();
        s_valid = 1'b0;
        check("sw_m_valid", m_valid, 1'b1);
        check("sw_m_sid", m_sid, 4'd2);
        check("sw_out_cnt", out_cnt, 3'd1);
        rsp_done = 1'b1;
        tick();
        rsp_done = 1'b0;

        // Fill to MAX_OUT, then a fifth accepted alongside a retirement
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_addr = 32'h0001_0000 + 32'(i * 4);
            tick();
        end
        s_addr = 32'h0001_0010;
        #1;
        check("full_out_cnt", out_cnt, 3'd4);
        check("full_s_ready", s_ready, 1'b0);
        rsp_done = 1'b1;
        #1;
        check("full_rsp_s_ready", s_ready, 1'b1);
        tick();
        s_valid  = 1'b0;
        check("full_hold_cnt", out_cnt, 3'd4);
        check("full_fifth_addr", m_addr, 32'h0001_0010);
        repeat (4) tick();
        rsp_done = 1'b0;
        check("full_drain_cnt", out_cnt, 3'd0);

        // Downstream backpressure holds the payload
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_addr  = 32'h0002_0100;
        tick();
        s_addr  = 32'h0002_0200;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_m_valid", m_valid, 1'b1);
            check("bp_m_addr", m_addr, 32'h0002_0100);
            check("bp_m_sid", m_sid, 4'd2);
            check("bp_s_ready", s_ready, 1'b0);
            tick();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        tick();
        check("bp_released", m_valid, 1'b0);
        check("bp_cnt", out_cnt, 3'd1);
        rsp_done = 1'b1;
        tick();
        check("bp_retire", out_cnt, 3'd0);
        tick();
        rsp_done = 1'b0;
        check("underflow_guard", out_cnt, 3'd0);

        // Asynchronous reset in the middle of a burst
        s_valid = 1'b1;
        s_addr  = 32'h0000_0100;
        tick();
        s_addr  = 32'h0000_0104;
        tick();
        check("burst_cnt", out_cnt, 3'd2);
        #2;
        ARESETn = 1'b0;
        #1;
        check("arst_m_valid", m_valid, 1'b0);
        check("arst_out_cnt", out_cnt, 3'd0);
        check("arst_s_ready", s_ready, 1'b0);
        s_valid = 1'b0;
        @(posedge ACLK);
        @(negedge ACLK);
        ARESETn = 1'b1;
        s_valid = 1'b1;
        s_addr  = 32'h0000_0000;
        #1;
        check("post_rst_s_ready", s_ready, 1'b1);
        tick();
        s_valid = 1'b0;
        check("post_rst_m_valid", m_valid, 1'b1);
        check("post_rst_m_addr", m_addr, 32'h0000_0000);
        check("post_rst_m_sid", m_sid, 4'd0);
        check("post_rst_cnt", out_cnt, 3'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
